ahbl_decoder_mux: RTL and testbench



---
 rtl/ahbl_pkg.sv | 25 ++
 rtl/ahbl_default_slave.sv | 60 ++++++
 rtl/ahbl_decoder_mux.sv | 112 +++++++++++
 tb/tb_ahbl_decoder_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and state types for the decoder/mux slice.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE,
    DS_ERR1,
    DS_ERR2
  } ds_state_e;

  // What the current data phase is routed to.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_SLAVE,
    SEL_DEF
  } sel_kind_e;

endpackage

// File: rtl/ahbl_default_slave.sv
// Built-in default slave: two-cycle ERROR response for unmapped transfers,
// plus capture of the faulting address and a saturating error count.
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_def,
  input  logic [31:0] haddr,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] err_addr,
  output logic [7:0]  err_cnt
);

  ds_state_e   state_q, state_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DS_IDLE;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hready     = 1'b1;
    hresp      = HRESP_OKAY;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      DS_IDLE: if (load_def) state_d = DS_ERR1;
      DS_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = DS_ERR2;
      end
      DS_ERR2: begin
        hresp   = HRESP_ERROR;
        state_d = load_def ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
    if (load_def) begin
      err_addr_d = haddr;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: rtl/ahbl_decoder_mux.sv
// AHB-Lite address decoder and response multiplexer for a single master,
// with a built-in default slave for unmapped regions.
module ahbl_decoder_mux
  import ahbl_pkg::*;
#(
  parameter int unsigned               NUM_SLAVES = 4,
  parameter int unsigned               DW         = 32,
  parameter logic [NUM_SLAVES*32-1:0]  BASE       = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*32-1:0]  MASK       = {NUM_SLAVES{32'hF000_0000}}
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic                     HREADY,
  output logic [DW-1:0]            HRDATA,
  output logic                     HRESP,
  output logic [NUM_SLAVES-1:0]    S_HSEL,
  input  logic [NUM_SLAVES*DW-1:0] S_HRDATA,
  input  logic [NUM_SLAVES-1:0]    S_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]    S_HRESP,
  output logic [31:0]              ERR_ADDR,
  output logic [7:0]               ERR_CNT
);

  localparam int unsigned IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          active;
  logic          load_def;
  logic          def_hready, def_hresp;

  sel_kind_e     sel_kind_q, sel_kind_d;
  logic [IW-1:0] sel_idx_q, sel_idx_d;

  // Lowest matching index wins, so S_HSEL is one-hot or zero.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    S_HSEL  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((HADDR & MASK[32*i +: 32]) == BASE[32*i +: 32])) begin
        hit       = 1'b1;
        hit_idx   = IW'(i);
        S_HSEL[i] = 1'b1;
      end
    end
  end

  assign active   = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign load_def = HREADY && active && !hit;

  always_comb begin
    sel_kind_d = sel_kind_q;
    sel_idx_d  = sel_idx_q;
    if (HREADY) begin
      if (!active) begin
        sel_kind_d = SEL_NONE;
      end else if (hit) begin
        sel_kind_d = SEL_SLAVE;
        sel_idx_d  = hit_idx;
      end else begin
        sel_kind_d = SEL_DEF;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_kind_q <= SEL_NONE;
      sel_idx_q  <= '0;
    end else begin
      sel_kind_q <= sel_kind_d;
      sel_idx_q  <= sel_idx_d;
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    case (sel_kind_q)
      SEL_SLAVE: begin
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
          if (sel_idx_q == IW'(i)) begin
            HREADY = S_HREADYOUT[i];
            HRESP  = S_HRESP[i];
            HRDATA = S_HRDATA[DW*i +: DW];
          end
        end
      end
      SEL_DEF: begin
        HREADY = def_hready;
        HRESP  = def_hresp;
      end
      default: ;
    endcase
  end

  ahbl_default_slave u_def (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .load_def (load_def),
    .haddr    (HADDR),
    .hready   (def_hready),
    .hresp    (def_hresp),
    .err_addr (ERR_ADDR),
    .err_cnt  (ERR_CNT)
  );

endmodule

// File: tb/tb_ahbl_decoder_mux.sv
// Self-checking bench for ahbl_decoder_mux: directed scenarios followed by
// randomized single transfers checked against a transfer-level model.
module tb_ahbl_decoder_mux;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [127:0] S_HRDATA;
  logic [3:0]   S_HREADYOUT;
  logic [3:0]   S_HRESP;

  logic         HREADY, HRESP;
  logic [31:0]  HRDATA, ERR_ADDR;
  logic [7:0]   ERR_CNT;
  logic [3:0]   S_HSEL;

  logic         o_hready, o_hresp;
  logic [31:0]  o_hrdata, o_err_addr;
  logic [7:0]   o_err_cnt;
  logic [3:0]   o_hsel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  m_cnt;
  logic [31:0] m_addr;

  always #5 HCLK = ~HCLK;

  ahbl_decoder_mux #(
    .NUM_SLAVES (4),
    .DW         (32),
    .BASE       ({32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
    .MASK       ({4{32'hF000_0000}})
  ) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .S_HSEL(S_HSEL),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_ADDR(ERR_ADDR), .ERR_CNT(ERR_CNT)
  );

  // Slave 0 covers the whole map and overlaps every other region.
  ahbl_decoder_mux #(
    .NUM_SLAVES (4),
    .DW         (32),
    .BASE       ({32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000}),
    .MASK       ({32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'h0000_0000})
  ) u_ovl (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(o_hready), .HRDATA(o_hrdata), .HRESP(o_hresp), .S_HSEL(o_hsel),
    .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .ERR_ADDR(o_err_addr), .ERR_CNT(o_err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory map of the default test configuration, by top address nibble.
  function automatic int ref_slave(input logic [31:0] a);
    logic [3:0] nib;
    nib = a[31:28];
    case (nib)
      4'h0:    return 0;
      4'h2:    return 1;
      4'h4:    return 2;
      4'h8:    return 3;
      default: return -1;
    endcase
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic rand_slaves();
    for (int i = 0; i < 4; i++) begin
      S_HREADYOUT[i]      = 1'($urandom);
      S_HRESP[i]          = 1'($urandom);
      S_HRDATA[32*i +: 32] = $urandom;
    end
  endtask

  // One isolated transfer: address phase, full data phase, then bus idle.
  task automatic do_xfer(input logic [31:0] a, input logic [1:0] t, input int waits,
                         input logic [31:0] rdata, input logic resp);
    int s;
    logic [3:0] exp_sel;
    s = ref_slave(a);
    exp_sel = (s >= 0) ? 4'(1 << s) : 4'b0000;
    HADDR  = a;
    HTRANS = t;
    rand_slaves();
    #1;
    chk("addr_hsel", 32'(S_HSEL), 32'(exp_sel));
    chk("addr_hready", 32'(HREADY), 32'd1);
    step();
    HTRANS = 2'b00;
    HADDR  = $urandom;
    if (t[1] && s >= 0) begin
      for (int k = 0; k <= waits; k++) begin
        rand_slaves();
        S_HREADYOUT[s] = (k == waits);
        if (k == waits) begin
          S_HRDATA[32*s +: 32] = rdata;
          S_HRESP[s]           = resp;
        end
        #1;
        chk("slv_hready", 32'(HREADY), (k == waits) ? 32'd1 : 32'd0);
        if (k == waits) begin
          chk("slv_hrdata", HRDATA, rdata);
          chk("slv_hresp", 32'(HRESP), 32'(resp));
        end
        step();
      end
    end else if (t[1]) begin
      m_cnt  = (m_cnt == 8'hFF) ? 8'hFF : m_cnt + 8'd1;
      m_addr = a;
      for (int k = 0; k < 2; k++) begin
        rand_slaves();
        #1;
        chk("def_hready", 32'(HREADY), (k == 1) ? 32'd1 : 32'd0);
        chk("def_hresp", 32'(HRESP), 32'd1);
        chk("def_hrdata", HRDATA, 32'd0);
        step();
      end
    end else begin
      rand_slaves();
      #1;
      chk("idle_hready", 32'(HREADY), 32'd1);
      chk("idle_hresp", 32'(HRESP), 32'd0);
      chk("idle_hrdata", HRDATA, 32'd0);
      step();
    end
    chk("err_addr", ERR_ADDR, m_addr);
    chk("err_cnt", 32'(ERR_CNT), 32'(m_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_cnt   = 8'h00;
    m_addr  = 32'h0;
    HRESETn = 1'b0;
    HADDR   = 32'h4000_0000;
    HTRANS  = 2'b10;
    rand_slaves();
    #2;
    chk("rst_hsel", 32'(S_HSEL), 32'h4);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_err_addr", ERR_ADDR, 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    HADDR = 32'h3000_0000;
    step();
    chk("rst_hold_hready", 32'(HREADY), 32'd1);
    chk("rst_hold_cnt", 32'(ERR_CNT), 32'd0);
    HTRANS = 2'b00;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();

    // Overlap: lowest index wins
    HADDR = 32'h2000_0000;
    #1;
    chk("ovl_hsel", 32'(o_hsel), 32'h1);
    chk("map_hsel", 32'(S_HSEL), 32'h2);
    step();

    do_xfer(32'h2000_0010, 2'b10, 0, 32'hDEAD_BEEF, 1'b0);
    do_xfer(32'h4000_0000, 2'b10, 3, 32'h1234_5678, 1'b0);
    do_xfer(32'h3000_0000, 2'b10, 0, 32'h0, 1'b0);
    do_xfer(32'h9000_0000, 2'b01, 0, 32'h0, 1'b0);
    do_xfer(32'h9000_0000, 2'b00, 0, 32'h0, 1'b0);

    // Back-to-back unmapped: second address phase held in ERR1, taken in ERR2
    HADDR = 32'h3000_0000; HTRANS = 2'b10;
    #1; chk("b2b_a_hready", 32'(HREADY), 32'd1);
    step();
    HADDR = 32'h5000_0004; HTRANS = 2'b10;
    #1; chk("b2b_e1a_hready", 32'(HREADY), 32'd0); chk("b2b_e1a_hresp", 32'(HRESP), 32'd1);
    step();
    chk("b2b_e2a_hready", 32'(HREADY), 32'd1); chk("b2b_e2a_hresp", 32'(HRESP), 32'd1);
    step();
    HTRANS = 2'b00;
    #1; chk("b2b_e1b_hready", 32'(HREADY), 32'd0); chk("b2b_e1b_hresp", 32'(HRESP), 32'd1);
    step();
    chk("b2b_e2b_hready", 32'(HREADY), 32'd1); chk("b2b_e2b_hresp", 32'(HRESP), 32'd1);
    step();
    chk("b2b_end_hready", 32'(HREADY), 32'd1); chk("b2b_end_hresp", 32'(HRESP), 32'd0);
    m_cnt  = m_cnt + 8'd2;
    m_addr = 32'h5000_0004;
    chk("b2b_err_addr", ERR_ADDR, m_addr);
    chk("b2b_err_cnt", 32'(ERR_CNT), 32'(m_cnt));

    for (int i = 0; i < 300; i++)
      do_xfer(32'h3000_0000 | (32'(i) << 2), (i % 2 == 0) ? 2'b10 : 2'b11, 0, 32'h0, 1'b0);
    chk("sat_err_cnt", 32'(ERR_CNT), 32'hFF);

    // Reset during ERR1 must clear everything before the next edge
    HADDR = 32'h7000_0000; HTRANS = 2'b10;
    step();
    HTRANS = 2'b00;
    #1; chk("pre_rst_hready", 32'(HREADY), 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    chk("arst_hready", 32'(HREADY), 32'd1);
    chk("arst_hresp", 32'(HRESP), 32'd0);
    chk("arst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("arst_err_addr", ERR_ADDR, 32'd0);
    m_cnt  = 8'h00;
    m_addr = 32'h0;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      logic [3:0]  nib;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0: nib = 4'h0;
          1: nib = 4'h2;
          2: nib = 4'h4;
          default: nib = 4'h8;
        endcase
        a[31:28] = nib;
      end
      do_xfer(a, 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
